zicsr_csr_file: RTL and testbench

- Architectural CSR storage and access unit for the ZICSR extension, in the computational stage.
- Consumes the per-CSR control structs (ZICSRType::csrCtrl: Name, DefaultValue, WriteEn, ReadEn, InternalWriteEn, InternalWriteData) from the CSR definition block upstream.
- Executes csrrw/csrrs/csrrc (and immediate forms) from the decoder.
- Returns read data to writeback and flags illegal accesses; writes commit one cycle after acceptance through a forwarding write buffer.

---
 rtl/zicsr_csr_file_pkg.sv | 25 ++
 rtl/zicsr_csr_file_counter.sv | 24 ++
 rtl/zicsr_csr_file.sv | 117 +++++++++++
 tb/tb_zicsr_csr_file.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zicsr_csr_file_pkg.sv
// zicsr_csr_file_pkg: ZICSRType package holding CSR op encoding, per-CSR control struct and address constants.
`ifndef XLEN
`define XLEN 32
`endif
package ZICSRType;
  localparam int XLEN = `XLEN;
  localparam int NUM_CSRS = 4;
  typedef enum logic [1:0] {OP_RSVD = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csrOp;
  typedef struct packed {
    logic [11:0]     Name;
    logic [XLEN-1:0] DefaultValue;
    logic            WriteEn;
    logic            ReadEn;
    logic            InternalWriteEn;
    logic [XLEN-1:0] InternalWriteData;
  } csrCtrl;
  localparam logic [11:0] ADDR_USTATUS   = 12'h000;
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
endpackage

// File: rtl/zicsr_csr_file_counter.sv
// zicsr_counter: 64-bit counter with increment enable and half-word write port.
module zicsr_counter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wr_data,
  output logic [63:0]     value
);
  localparam logic [63:0] LO_MASK = XLEN == 64 ? '1 : 64'h0000_0000_FFFF_FFFF;
  logic [63:0] wd, nxt;
  always_comb begin
    wd = 64'(wr_data);
    nxt = wr_lo ? (value & ~LO_MASK) | (wd & LO_MASK) : value;
    nxt[63:32] = wr_hi ? wd[31:0] : nxt[63:32];
  end
  // a written half wins outright: no increment, hence no carry into it
  always_ff @(posedge clk or negedge reset)
    if (!reset) value <= '0;
    else value <= wr_lo || wr_hi ? nxt : value + 64'(inc);
endmodule

// File: rtl/zicsr_csr_file.sv
// zicsr_csr_file: ZICSR CSR storage/access unit with a one-deep forwarding write buffer.
// Define ZICSR_COUNTERS_EN to add 64-bit mcycle/minstret counters.
module zicsr_csr_file
  import ZICSRType::*;
#(
  parameter int NUM_CSRS = ZICSRType::NUM_CSRS
) (
  input  logic            clk,
  input  logic            reset,
  input  csrCtrl          csr_ctrl [NUM_CSRS],
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [11:0]     req_addr,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_rd_nz,
  input  logic            req_src_nz,
  input  logic            stall,
  input  logic            flush,
  input  logic            instr_retire,
  output logic [XLEN-1:0] rd_data,
  output logic            illegal
);
  localparam int NE = NUM_CSRS + 4;
  localparam int IW = $clog2(NE);
  localparam logic [0:0] INIT = 1'b0, RUN = 1'b1;
  localparam logic [11:0] CNT_ADDR [4] = '{ADDR_MCYCLE, ADDR_MINSTRET, ADDR_MCYCLEH, ADDR_MINSTRETH};
  logic [0:0]      state;
  logic [XLEN-1:0] regs [NUM_CSRS];
  logic            pend_valid, commit, accept_wr, active, hit, rd_en, wr_en;
  logic [IW-1:0]   pend_idx, idx;
  logic [XLEN-1:0] pend_data, old_val, new_val;
  logic [11:0]     ent_name [NE];
  logic            ent_on [NE], ent_re [NE], ent_we [NE];
  logic [XLEN-1:0] ent_val [NE], cnt_val [4];
  logic [63:0]     mcycle, minstret;
`ifdef ZICSR_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
  // entries NUM_CSRS+0..3 are mcycle, minstret, mcycleh, minstreth
  zicsr_counter #(.XLEN(XLEN)) u_mcycle (
    .clk, .reset, .inc(state == RUN),
    .wr_lo(commit && pend_idx == IW'(NUM_CSRS)), .wr_hi(commit && pend_idx == IW'(NUM_CSRS + 2)),
    .wr_data(pend_data), .value(mcycle)
  );
  zicsr_counter #(.XLEN(XLEN)) u_minstret (
    .clk, .reset, .inc(instr_retire),
    .wr_lo(commit && pend_idx == IW'(NUM_CSRS + 1)), .wr_hi(commit && pend_idx == IW'(NUM_CSRS + 3)),
    .wr_data(pend_data), .value(minstret)
  );
`else
  localparam bit CNT_ON = 1'b0;
  logic unused_retire;
  assign unused_retire = instr_retire;
  assign mcycle = '0;
  assign minstret = '0;
`endif
  assign cnt_val[0] = mcycle[XLEN-1:0];
  assign cnt_val[1] = minstret[XLEN-1:0];
  assign cnt_val[2] = XLEN'(mcycle[63:32]);
  assign cnt_val[3] = XLEN'(minstret[63:32]);
  always_comb begin
    for (int i = 0; i < NUM_CSRS; i++) begin
      ent_name[i] = csr_ctrl[i].Name;
      ent_on[i] = 1'b1;
      ent_re[i] = csr_ctrl[i].ReadEn;
      ent_we[i] = csr_ctrl[i].WriteEn;
      ent_val[i] = regs[i];
    end
    for (int i = 0; i < 4; i++) begin
      ent_name[NUM_CSRS+i] = CNT_ADDR[i];
      ent_on[NUM_CSRS+i] = CNT_ON && (i < 2 || XLEN == 32);
      ent_re[NUM_CSRS+i] = 1'b1;
      ent_we[NUM_CSRS+i] = 1'b1;
      ent_val[NUM_CSRS+i] = cnt_val[i];
    end
    hit = 1'b0;
    idx = '0;
    for (int i = NE - 1; i >= 0; i--)
      if (ent_on[i] && ent_name[i] == req_addr) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    rd_en = req_op != OP_RW || req_rd_nz;
    wr_en = req_op == OP_RW || req_src_nz;
    old_val = pend_valid && pend_idx == idx && !flush ? pend_data : ent_val[idx];
    new_val = req_op == OP_RS ? old_val | req_src : req_op == OP_RC ? old_val & ~req_src : req_src;
    active = state == RUN && req_valid;
    illegal = active && (req_op == OP_RSVD || !hit || (rd_en && !ent_re[idx]) ||
              (wr_en && (!ent_we[idx] || req_addr[11:10] == 2'b11)));
    rd_data = active && hit && rd_en ? old_val : '0;
  end
  assign req_ready = state == RUN;
  assign accept_wr = active && !stall && !illegal && !flush && wr_en;
  assign commit = pend_valid && !flush;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= INIT;
      pend_valid <= 1'b0;
      pend_idx <= '0;
      pend_data <= '0;
    end else begin
      state <= RUN;
      pend_valid <= accept_wr;
      if (accept_wr) begin
        pend_idx <= idx;
        pend_data <= new_val;
      end
    end
  // an internal write outranks a same-cycle commit to the same entry
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NUM_CSRS; i++) regs[i] <= '0;
    else
      for (int i = 0; i < NUM_CSRS; i++)
        regs[i] <= state == INIT ? csr_ctrl[i].DefaultValue :
                   csr_ctrl[i].InternalWriteEn ? csr_ctrl[i].InternalWriteData :
                   commit && pend_idx == IW'(i) ? pend_data : regs[i];
endmodule

// File: tb/tb_zicsr_csr_file.sv
// tb_zicsr_csr_file: directed vector table, hand sequences and random run against an address-level CSR model.
module tb_zicsr_csr_file;
  import ZICSRType::*;
`ifdef ZICSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif
  localparam logic [11:0] NAMES [4] = '{12'h300, 12'h305, 12'hF14, 12'h000};
  localparam logic [31:0] DEFS [4] = '{32'h1880, 32'h100, 32'h0, 32'h0};
  localparam bit WEN [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit REN [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [11:0] POOL [10] = '{12'h300, 12'h305, 12'hF14, 12'h000, 12'h7C0,
                                        12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h343};

  logic clk = 1'b0, reset = 1'b0;
  csrCtrl csr_ctrl [4];
  logic req_valid, req_ready, req_rd_nz, req_src_nz, stall, flush, instr_retire, illegal;
  logic [11:0] req_addr;
  logic [1:0] req_op;
  logic [XLEN-1:0] req_src, rd_data;

  zicsr_csr_file #(.NUM_CSRS(4)) dut (
    .clk(clk), .reset(reset), .csr_ctrl(csr_ctrl), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op), .req_src(req_src), .req_rd_nz(req_rd_nz),
    .req_src_nz(req_src_nz), .stall(stall), .flush(flush), .instr_retire(instr_retire),
    .rd_data(rd_data), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  bit m_run, m_pv;
  logic [11:0] m_pa;
  logic [31:0] m_pd, m_reg [4];
  logic [63:0] m_cyc, m_ret;
  logic [31:0] e_rd, e_nv;
  bit e_ill, e_ready, e_acc;

  typedef struct {
    logic v; logic [11:0] a; logic [1:0] op; logic [31:0] src;
    logic rdnz, srcnz, stl, fl; logic [31:0] erd; logic eill; bit crd;
  } vec_t;
  vec_t tab [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic int find(input logic [11:0] a);
    for (int k = 0; k < 4; k++) if (NAMES[k] == a) return k;
    return -1;
  endfunction

  function automatic bit is_cnt(input logic [11:0] a);
    return CNT && (a == 12'hB00 || a == 12'hB02 || a == 12'hB80 || a == 12'hB82);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [11:0] a);
    int k = find(a);
    if (k >= 0) return m_reg[k];
    return a == 12'hB00 ? m_cyc[31:0] : a == 12'hB80 ? m_cyc[63:32] :
           a == 12'hB02 ? m_ret[31:0] : m_ret[63:32];
  endfunction

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_cyc = 0; m_ret = 0;
    for (int k = 0; k < 4; k++) m_reg[k] = 0;
  endtask

  task automatic eval_model();
    int k = find(req_addr);
    bit ex = k >= 0 || is_cnt(req_addr);
    bit ren = k >= 0 ? REN[k] : 1'b1;
    bit wen = k >= 0 ? WEN[k] : 1'b1;
    bit rde = req_op != 2'b01 || req_rd_nz;
    bit wre = req_op == 2'b01 || req_src_nz;
    bit act = m_run && req_valid;
    logic [31:0] old = (m_pv && m_pa == req_addr && !flush) ? m_pd : (ex ? arch_rd(req_addr) : 32'h0);
    e_ready = m_run;
    e_ill = act && (req_op == 2'b00 || !ex || (rde && !ren) || (wre && (!wen || req_addr[11:10] == 2'b11)));
    e_rd = act && ex && rde ? old : 32'h0;
    case (req_op)
      2'b10: e_nv = old | req_src;
      2'b11: e_nv = old & ~req_src;
      default: e_nv = req_src;
    endcase
    e_acc = act && !stall && !e_ill && !flush && wre;
  endtask

  task automatic model_edge();
    bit cw_cyc = 0, cw_ret = 0;
    if (!m_run) begin
      for (int k = 0; k < 4; k++) m_reg[k] = DEFS[k];
      m_run = 1; m_pv = 0;
      return;
    end
    if (m_pv && !flush) begin
      int k = find(m_pa);
      if (k >= 0) begin
        if (!csr_ctrl[k].InternalWriteEn) m_reg[k] = m_pd;
      end else if (m_pa == 12'hB00) begin m_cyc[31:0] = m_pd; cw_cyc = 1; end
      else if (m_pa == 12'hB80) begin m_cyc[63:32] = m_pd; cw_cyc = 1; end
      else if (m_pa == 12'hB02) begin m_ret[31:0] = m_pd; cw_ret = 1; end
      else begin m_ret[63:32] = m_pd; cw_ret = 1; end
    end
    for (int k = 0; k < 4; k++) if (csr_ctrl[k].InternalWriteEn) m_reg[k] = csr_ctrl[k].InternalWriteData;
    if (!cw_cyc) m_cyc = m_cyc + 1;
    if (!cw_ret && instr_retire) m_ret = m_ret + 1;
    m_pv = e_acc; m_pa = req_addr; m_pd = e_nv;
  endtask

  task automatic look();
    #2;
    eval_model();
  endtask

  task automatic clock();
    eval_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [11:0] a, input logic [1:0] op, input logic [31:0] src,
                       input logic rdnz, input logic srcnz, input logic stl, input logic fl);
    req_valid = v; req_addr = a; req_op = op; req_src = src;
    req_rd_nz = rdnz; req_src_nz = srcnz; stall = stl; flush = fl;
  endtask

  function automatic void add(input logic v, input logic [11:0] a, input logic [1:0] op, input logic [31:0] src,
                              input logic rdnz, input logic srcnz, input logic stl, input logic fl,
                              input logic [31:0] erd, input logic eill, input bit crd);
    vec_t t;
    t.v = v; t.a = a; t.op = op; t.src = src; t.rdnz = rdnz; t.srcnz = srcnz;
    t.stl = stl; t.fl = fl; t.erd = erd; t.eill = eill; t.crd = crd;
    tab.push_back(t);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      csr_ctrl[k].Name = NAMES[k]; csr_ctrl[k].DefaultValue = DEFS[k];
      csr_ctrl[k].WriteEn = WEN[k]; csr_ctrl[k].ReadEn = REN[k];
      csr_ctrl[k].InternalWriteEn = 1'b0; csr_ctrl[k].InternalWriteData = '0;
    end
    drive(1, 12'h300, 2'b10, 0, 1, 0, 0, 0);
    instr_retire = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    look();
    check("reset ready", req_ready, 0);
    check("reset rd_data", rd_data, 0);
    reset = 1'b1;
    look();
    check("init ready", req_ready, e_ready);
    check("init ready const", req_ready, 0);
    check("init rd_data", rd_data, 0);
    check("init illegal", illegal, 0);
    clock();
    look();
    check("run ready", req_ready, 1);

    //   v  addr     op     src          rdnz srcnz stl fl  exp_rd      ill  chk_rd
    add(1, 12'h300, 2'b10, 32'h0,       1,   0,    0,  0,  32'h1880,   0,   1);
    add(1, 12'h300, 2'b01, 32'h8,       1,   1,    0,  0,  32'h1880,   0,   1);
    add(1, 12'h300, 2'b10, 32'h1,       1,   1,    0,  0,  32'h8,      0,   1);
    add(1, 12'h300, 2'b10, 32'h0,       1,   0,    0,  0,  32'h9,      0,   1);
    add(1, 12'hF14, 2'b01, 32'h5,       1,   1,    0,  0,  32'h0,      1,   0);
    add(1, 12'hF14, 2'b10, 32'h0,       1,   0,    0,  0,  32'h0,      0,   1);
    add(1, 12'h7C0, 2'b01, 32'h1,       1,   1,    0,  0,  32'h0,      1,   0);
    add(1, 12'hF14, 2'b10, 32'h0,       1,   0,    0,  0,  32'h0,      0,   1);
    add(1, 12'h300, 2'b01, 32'h1880,    0,   1,    0,  0,  32'h0,      0,   1);
    add(1, 12'h300, 2'b11, 32'h80,      1,   1,    0,  0,  32'h1880,   0,   1);
    add(1, 12'h300, 2'b10, 32'h0,       1,   0,    0,  1,  32'h1880,   0,   1);
    add(1, 12'h300, 2'b10, 32'h0,       1,   0,    0,  0,  32'h1880,   0,   1);
    add(1, 12'h305, 2'b01, 32'h200,     1,   1,    1,  0,  32'h100,    0,   1);
    add(1, 12'h305, 2'b10, 32'h0,       1,   0,    0,  0,  32'h100,    0,   1);
    add(1, 12'h000, 2'b10, 32'h0,       1,   0,    0,  0,  32'h0,      1,   0);
    add(1, 12'h000, 2'b01, 32'h11,      0,   1,    0,  0,  32'h0,      0,   1);
    add(1, 12'h000, 2'b01, 32'h22,      0,   1,    0,  0,  32'h0,      0,   1);
    add(1, 12'h300, 2'b00, 32'h0,       1,   0,    0,  0,  32'h0,      1,   0);
    add(0, 12'hF14, 2'b01, 32'h5,       1,   1,    0,  0,  32'h0,      0,   1);
    add(1, 12'hB00, 2'b10, 32'h0,       1,   0,    0,  0,  32'h0,      !CNT, 0);
    foreach (tab[i]) begin
      drive(tab[i].v, tab[i].a, tab[i].op, tab[i].src, tab[i].rdnz, tab[i].srcnz, tab[i].stl, tab[i].fl);
      look();
      check($sformatf("vec%0d illegal", i), illegal, tab[i].eill);
      if (tab[i].crd) check($sformatf("vec%0d rd_data", i), rd_data, tab[i].erd);
      clock();
    end

    // internal write beats a same-cycle pending commit
    drive(1, 12'h300, 2'b01, 32'h55, 0, 1, 0, 0);
    clock();
    drive(0, 12'h300, 2'b10, 0, 1, 0, 0, 0);
    csr_ctrl[0].InternalWriteEn = 1; csr_ctrl[0].InternalWriteData = 32'hAA;
    clock();
    csr_ctrl[0].InternalWriteEn = 0;
    drive(1, 12'h300, 2'b10, 0, 1, 0, 0, 0);
    look();
    check("iw beats commit", rd_data, 32'hAA);
    // internal write is not forwarded
    csr_ctrl[0].InternalWriteEn = 1; csr_ctrl[0].InternalWriteData = 32'h77;
    look();
    check("iw not forwarded", rd_data, 32'hAA);
    clock();
    csr_ctrl[0].InternalWriteEn = 0;
    look();
    check("iw visible next", rd_data, 32'h77);
    clock();

    // reset with a pending write in flight
    drive(1, 12'h305, 2'b01, 32'h333, 0, 1, 0, 0);
    clock();
    drive(1, 12'h305, 2'b10, 0, 1, 0, 0, 0);
    reset = 1'b0;
    model_reset();
    look();
    check("midreset ready", req_ready, 0);
    check("midreset rd_data", rd_data, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    look();
    check("re-init ready", req_ready, 0);
    clock();
    look();
    check("re-run ready", req_ready, 1);
    check("pending discarded", rd_data, 32'h100);
    clock();

    if (CNT) begin
      drive(0, 12'h300, 2'b10, 0, 1, 0, 0, 0);
      for (int r = 0; r < 3; r++) begin instr_retire = 1; clock(); end
      instr_retire = 0;
      drive(1, 12'hB02, 2'b10, 0, 1, 0, 0, 0);
      look();
      check("minstret=3", rd_data, 32'd3);
      check("minstret illegal", illegal, 0);
      clock();
      drive(1, 12'hB00, 2'b01, 32'hFFFF_FFFF, 0, 1, 0, 0);
      clock();
      drive(0, 12'h300, 2'b10, 0, 1, 0, 0, 0);
      clock();
      clock();
      drive(1, 12'hB80, 2'b10, 0, 1, 0, 0, 0);
      look();
      check("mcycleh carry", rd_data, 32'd1);
      clock();
    end

    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 5) == 0 ? 12'($urandom) : POOL[$urandom_range(0, 9)],
            2'($urandom_range(0, 3)),
            $urandom_range(0, 1) ? $urandom : 32'(1 << $urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      for (int k = 0; k < 4; k++) begin
        csr_ctrl[k].InternalWriteEn = $urandom_range(0, 9) == 0;
        csr_ctrl[k].InternalWriteData = $urandom;
      end
      instr_retire = 1'($urandom_range(0, 1));
      look();
      check($sformatf("rnd%0d ready", c), req_ready, e_ready);
      check($sformatf("rnd%0d illegal", c), illegal, e_ill);
      if (!e_ill) check($sformatf("rnd%0d rd_data", c), rd_data, e_rd);
      clock();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
